// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: request/grant/read-return bundle between two requesters, the arbiter and the RAM.
// Ports (signals): a_*/b_* requester side (req, we, addr, wdata, lock in; gnt, rvalid, rdata out);
//   ram_addr/ram_wdata/ram_we toward the RAM, ram_rdata back from it; owner and busy status.
// Modports: slave = arbiter view, master = requester/RAM view.
interface spram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, owner, busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_lock,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        input  ram_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_addr, ram_wdata, ram_we, owner, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_lock,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        output ram_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_addr, ram_wdata, ram_we, owner, busy
    );
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter: round-robin two-port sequencer onto one single-port RAM with registered read data.
// Ports: clk (rising edge); reset_n (synchronous, active low);
//   bus (slave modport): A/B requests with optional lock, one-cycle gnt and rvalid pulses,
//   held rdata per port, RAM address/write data/write enable out, RAM read data in,
//   owner (0=A, 1=B, current or last) and busy (access or read wait in progress).
module spram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input logic            clk,
    input logic            reset_n,
    spram_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d, we_q, we_d, lock_q, lock_d;
    logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          both, keep, win;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b1;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            lock_q     <= lock_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        both       = bus.a_req && bus.b_req;
        // a locked owner keeps the port against a contender only until MAX_LOCK extra grants
        keep       = lock_q && (cnt_q < CW'(MAX_LOCK));
        win        = both ? (keep ? owner_q : !owner_q) : bus.b_req;
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        lock_d     = lock_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        case (state_q)
            IDLE: if (bus.a_req || bus.b_req) begin
                state_d = ACCESS;
                owner_d = win;
                we_d    = win ? bus.b_we : bus.a_we;
                addr_d  = win ? bus.b_addr : bus.a_addr;
                wdata_d = win ? bus.b_wdata : bus.a_wdata;
                // the counter only runs while the lock actually holds off a waiting port
                cnt_d   = (both && keep) ? cnt_q + 1'b1 : '0;
            end
            ACCESS: begin
                state_d = we_q ? IDLE : RDWAIT;
                lock_d  = owner_q ? bus.b_lock : bus.a_lock;
            end
            RDWAIT: begin
                state_d    = IDLE;
                a_rvalid_d = !owner_q;
                b_rvalid_d = owner_q;
                a_rdata_d  = owner_q ? a_rdata_q : bus.ram_rdata;
                b_rdata_d  = owner_q ? bus.ram_rdata : b_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.a_gnt     = (state_q == ACCESS) && !owner_q;
    assign bus.b_gnt     = (state_q == ACCESS) && owner_q;
    assign bus.ram_we    = (state_q == ACCESS) && we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
endmodule
